// File: rtl/display_stream_out_if.sv
// Handshake bundle between display_stream_out (master) and its environment:
// frame-buffer byte pull on one side, RGB565 pixel stream on the other.
interface display_stream_out_if;
    // Valid/ready: a byte moves when enc_rd_data_ready & enc_data_req are both high on an
    // edge; a pixel moves when px_valid & px_ready are both high on an edge. A raised
    // px_valid, together with px_data and the framing flags, holds until that edge.
    logic        decompress_start;
    logic        enc_rd_data_ready;
    logic [7:0]  enc_rd_data_out;
    logic        enc_rd_data_out_finish;
    logic        enc_data_req;
    logic [15:0] px_data;
    logic        px_valid;
    logic        px_ready;
    logic        px_sof;
    logic        px_eol;
    logic        px_eof;

    modport master (
        output decompress_start,
        output enc_data_req,
        output px_data,
        output px_valid,
        output px_sof,
        output px_eol,
        output px_eof,
        input  enc_rd_data_ready,
        input  enc_rd_data_out,
        input  enc_rd_data_out_finish,
        input  px_ready
    );

    modport slave (
        input  decompress_start,
        input  enc_data_req,
        input  px_data,
        input  px_valid,
        input  px_sof,
        input  px_eol,
        input  px_eof,
        output enc_rd_data_ready,
        output enc_rd_data_out,
        output enc_rd_data_out_finish,
        output px_ready
    );
endinterface

// File: rtl/display_stream_out.sv
// Pulls frame-buffer bytes, packs byte pairs into RGB565 pixels and streams framed lines.
// Define DSO_UNDERRUN_FILL_EN to pad an underrun frame with FILL_COLOR instead of aborting.
module display_stream_out #(
    parameter int unsigned H_PIXELS   = 240,
    parameter int unsigned V_LINES    = 240,
    parameter logic [15:0] FILL_COLOR = 16'h0000
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 inter_reset,
    input  logic                 play_en,
    input  logic                 frame_tick,
    display_stream_out_if.master bus,
    output logic                 frame_done,
    output logic                 underrun,
    output logic                 frame_overrun,
    output logic [2:0]           state_dbg
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_START    = 3'd1;
    localparam logic [2:0] ST_WAIT_RDY = 3'd2;
    localparam logic [2:0] ST_HI       = 3'd3;
    localparam logic [2:0] ST_LO       = 3'd4;
    localparam logic [2:0] ST_DRAIN    = 3'd5;
    localparam logic [2:0] ST_DONE     = 3'd6;
`ifdef DSO_UNDERRUN_FILL_EN
    localparam logic [2:0] ST_FILL     = 3'd7;
    localparam logic [2:0] ST_ON_DRY   = ST_FILL;
`else
    localparam logic [2:0] ST_ON_DRY   = ST_DRAIN;
    logic unused_fill_color;
    assign unused_fill_color = ^FILL_COLOR;
`endif

    localparam logic [8:0] X_LAST = 9'(H_PIXELS - 1);
    localparam logic [8:0] Y_LAST = 9'(V_LINES - 1);

    logic [2:0]  state_q, state_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] px_data_q, px_data_d;
    logic        px_valid_q, px_valid_d;
    logic        sof_q, sof_d;
    logic        eol_q, eol_d;
    logic        eof_q, eof_d;
    logic [8:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic        underrun_q, underrun_d;
    logic        overrun_q, overrun_d;

    logic        req;
    logic        load;
    logic [15:0] load_px;
    logic        slot_free;
    logic        at_last;
    logic        dry;

    assign slot_free = ~px_valid_q | bus.px_ready;
    assign at_last   = (x_q == X_LAST) && (y_q == Y_LAST);
    // Running out of bytes is seen either as ready dropping or as the explicit finish pulse.
    assign dry       = ~bus.enc_rd_data_ready | bus.enc_rd_data_out_finish;

    always_comb begin
        state_d    = state_q;
        hi_d       = hi_q;
        px_data_d  = px_data_q;
        px_valid_d = px_valid_q;
        sof_d      = sof_q;
        eol_d      = eol_q;
        eof_d      = eof_q;
        x_d        = x_q;
        y_d        = y_q;
        underrun_d = underrun_q;
        overrun_d  = overrun_q;
        req        = 1'b0;
        load       = 1'b0;
        load_px    = {hi_q, bus.enc_rd_data_out};

        if (px_valid_q && bus.px_ready) begin
            px_valid_d = 1'b0;
        end
        if (frame_tick && (state_q != ST_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_tick && play_en) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_WAIT_RDY;
            end
            ST_WAIT_RDY: begin
                if (bus.enc_rd_data_ready) begin
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                if (dry) begin
                    underrun_d = 1'b1;
                    state_d    = ST_ON_DRY;
                end else begin
                    req     = 1'b1;
                    hi_d    = bus.enc_rd_data_out;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                if (dry) begin
                    underrun_d = 1'b1;
                    state_d    = ST_ON_DRY;
                end else if (slot_free) begin
                    req     = 1'b1;
                    load    = 1'b1;
                    state_d = at_last ? ST_DRAIN : ST_HI;
                end
            end
`ifdef DSO_UNDERRUN_FILL_EN
            ST_FILL: begin
                if (slot_free) begin
                    load    = 1'b1;
                    load_px = FILL_COLOR;
                    if (at_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
`endif
            ST_DRAIN: begin
                // Also covers an abort with an empty output reg: falls straight through.
                if (slot_free) begin
                    px_valid_d = 1'b0;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                x_d     = 9'd0;
                y_d     = 9'd0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load) begin
            px_data_d  = load_px;
            px_valid_d = 1'b1;
            sof_d      = (x_q == 9'd0) && (y_q == 9'd0);
            eol_d      = (x_q == X_LAST);
            eof_d      = at_last;
            if (x_q == X_LAST) begin
                x_d = 9'd0;
                y_d = (y_q == Y_LAST) ? 9'd0 : y_q + 9'd1;
            end else begin
                x_d = x_q + 9'd1;
            end
        end

        if (!inter_reset) begin
            state_d    = ST_IDLE;
            hi_d       = 8'd0;
            px_data_d  = 16'd0;
            px_valid_d = 1'b0;
            sof_d      = 1'b0;
            eol_d      = 1'b0;
            eof_d      = 1'b0;
            x_d        = 9'd0;
            y_d        = 9'd0;
            underrun_d = 1'b0;
            overrun_d  = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            hi_q       <= 8'd0;
            px_data_q  <= 16'd0;
            px_valid_q <= 1'b0;
            sof_q      <= 1'b0;
            eol_q      <= 1'b0;
            eof_q      <= 1'b0;
            x_q        <= 9'd0;
            y_q        <= 9'd0;
            underrun_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            px_data_q  <= px_data_d;
            px_valid_q <= px_valid_d;
            sof_q      <= sof_d;
            eol_q      <= eol_d;
            eof_q      <= eof_d;
            x_q        <= x_d;
            y_q        <= y_d;
            underrun_q <= underrun_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.decompress_start = (state_q == ST_START);
    assign bus.enc_data_req     = req;
    assign bus.px_data          = px_data_q;
    assign bus.px_valid         = px_valid_q;
    assign bus.px_sof           = sof_q;
    assign bus.px_eol           = eol_q;
    assign bus.px_eof           = eof_q;
    assign frame_done           = (state_q == ST_DONE);
    assign underrun             = underrun_q;
    assign frame_overrun        = overrun_q;
    assign state_dbg            = state_q;

endmodule
